// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared constants and types for the framebuffer scanout arbiter.
// The scan FSM and the pixel FIFO both import this package.
package fb_scanout_arbiter_pkg;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned V_RES  = 480;
  localparam int unsigned ADDR_W = 19;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } scan_state_e;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Prefetch FIFO between framebuffer reads and the pixel pipeline.
// Pop on empty is ignored; head reads as zero when empty.
module pix_fifo
  import fb_scanout_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  rgb332_t                      push_data,
  input  logic                         pop,
  output rgb332_t                      head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rgb332_t         mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_pop;
  logic            do_push;

  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count_q != '0);
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);
  assign head    = valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Single-port SRAM arbiter: scanout prefetch reads take priority over host writes.
// Reads are credit-limited so the prefetch FIFO can never overflow.
module fb_scanout_arbiter #(
  parameter int unsigned H_RES  = fb_scanout_arbiter_pkg::H_RES,
  parameter int unsigned V_RES  = fb_scanout_arbiter_pkg::V_RES,
  parameter int unsigned ADDR_W = fb_scanout_arbiter_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              c25,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [7:0]        pixel_out,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  import fb_scanout_arbiter_pkg::*;

  localparam int unsigned       CntW     = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(frame_pixels(H_RES, V_RES) - 1);

  scan_state_e       state_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic              rd_pend_q;
  logic [1:0]        inflight;
  logic [CntW-1:0]   fifo_count;
  logic              credit_ok;
  logic              scan_grant;
  logic              wr_grant;
  logic              capture;
  rgb332_t           rdata_px;
  rgb332_t           head_px;

  // One command per cycle, so at most the read issued last edge is uncaptured.
  assign inflight   = {1'b0, rd_pend_q};
  assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < DEPTH;
  assign scan_grant = (state_q == StFill) && credit_ok && !frame_start;
  // Blocking on wr_ack keeps a still-held request from being issued twice.
  assign wr_grant   = !scan_grant && wr_req && !wr_ack;
  // Data returning across a frame_start belongs to the old frame and is dropped.
  assign capture    = rd_pend_q && !frame_start;
  assign rdata_px   = rgb332_t'(mem_rdata);
  assign pixel_out  = head_px;

  pix_fifo #(
    .DEPTH (DEPTH)
  ) u_pix_fifo (
    .clk       (c25),
    .rst       (Reset),
    .flush     (frame_start),
    .push      (capture),
    .push_data (rdata_px),
    .pop       (pix_pop),
    .head      (head_px),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge c25 or posedge Reset) begin
    if (Reset) begin
      state_q     <= StFill;
      scan_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      wr_ack      <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      rd_pend_q <= scan_grant;
      mem_we    <= wr_grant;
      wr_ack    <= wr_grant;

      if (scan_grant) begin
        mem_addr <= scan_addr_q;
      end else if (wr_grant) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      if (frame_start) begin
        state_q     <= StFill;
        scan_addr_q <= '0;
      end else if (scan_grant) begin
        if (scan_addr_q == LastAddr) begin
          state_q <= StHold;
        end else begin
          scan_addr_q <= scan_addr_q + 1'b1;
        end
      end

      if (pix_pop && !pix_valid) underflow <= 1'b1;
    end
  end

endmodule
